// File: rtl/toxic_alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters.
// Define TOXIC_ALU_ARB_PERF_EN to add grant/stall performance counters.
module toxic_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_b,
  input  logic [NUM_REQ*2-1:0]      req_aluop,
  output logic [DATA_W-1:0]         alu_operand_a,
  output logic [DATA_W-1:0]         alu_operand_b,
  output logic [1:0]                alu_aluop,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_carry,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_carry,
`ifdef TOXIC_ALU_ARB_PERF_EN
  output logic [15:0]               perf_grant_cnt,
  output logic [15:0]               perf_stall_cnt,
`endif
  input  logic                      rsp_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  logic [1:0]      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] pick;
  logic            hit;
  logic            accept;
  int              idx;

  // Search for the next valid requester after the previous winner.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!hit && req_valid[idx]) begin
        hit  = 1'b1;
        pick = ID_W'(idx);
      end
    end
  end

  assign accept = hit && (state == IDLE) && !rst;

  // One-hot ready only for the winner, and only while idle.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = NUM_REQ'(1) << pick;
    end
  end

  // Grant, execute and respond sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= LAST_RST;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_carry     <= 1'b0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_aluop     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_operand_a <= req_op_a[pick*DATA_W +: DATA_W];
            alu_operand_b <= req_op_b[pick*DATA_W +: DATA_W];
            alu_aluop     <= req_aluop[pick*2 +: 2];
            last_grant    <= pick;
            rsp_id        <= pick;
            state         <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef TOXIC_ALU_ARB_PERF_EN
  logic stall;

  assign stall = (|req_valid) && (req_ready == '0);

  // Saturating counters of accepted requests and stalled request cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept && perf_grant_cnt != 16'hFFFF) begin
        perf_grant_cnt <= perf_grant_cnt + 16'd1;
      end
      if (stall && perf_stall_cnt != 16'hFFFF) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_toxic_alu_arbiter.sv
// Directed self-checking bench for toxic_alu_arbiter.
// Drives at posedge+1, samples at negedge.
module tb_toxic_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_op_a;
  logic [15:0] req_op_b;
  logic [7:0]  req_aluop;
  logic [3:0]  alu_operand_a;
  logic [3:0]  alu_operand_b;
  logic [1:0]  alu_aluop;
  logic [3:0]  alu_result;
  logic        alu_carry;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic        rsp_carry;
  logic        rsp_ready;
`ifdef TOXIC_ALU_ARB_PERF_EN
  logic [15:0] perf_grant_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  toxic_alu_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .req_aluop     (req_aluop),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_aluop     (alu_aluop),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
`ifdef TOXIC_ALU_ARB_PERF_EN
    .perf_grant_cnt(perf_grant_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .rsp_ready     (rsp_ready)
  );

  // ALU stand-in: add, sub, and, or.
  always_comb begin
    {alu_carry, alu_result} = 5'd0;
    case (alu_aluop)
      2'd0: {alu_carry, alu_result} = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
      2'd1: {alu_carry, alu_result} = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
      2'd2: {alu_carry, alu_result} = {1'b0, alu_operand_a & alu_operand_b};
      default: {alu_carry, alu_result} = {1'b0, alu_operand_a | alu_operand_b};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    int g;
    int r;
    int last;

    rst       = 1'b1;
    req_valid = 4'hF;
    req_op_a  = 16'h0002;
    req_op_b  = 16'h0003;
    req_aluop = 8'h00;
    rsp_ready = 1'b1;

    // reset held with all requests valid
    drv();
    drv();
    smp();
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_alu", {alu_operand_a, alu_operand_b, alu_aluop}, 0);
`ifdef TOXIC_ALU_ARB_PERF_EN
    chk("rst_perf", {perf_grant_cnt, perf_stall_cnt}, 0);
`endif
    drv();
    rst = 1'b0;
    smp();
    chk("first_grant", req_ready, 4'b0001);
    drv();
    req_valid = 4'h0;
    smp();
    chk("first_alu_a", alu_operand_a, 4'h2);
    chk("first_alu_b", alu_operand_b, 4'h3);
    drv();
    smp();
    chk("first_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry}, {1'b1, 2'd0, 4'h5, 1'b0});

    // single op from requester 1: 3 + 5
    drv();
    req_valid = 4'b0010;
    req_op_a  = 16'h0030;
    req_op_b  = 16'h0050;
    smp();
    chk("single_ready", req_ready, 4'b0010);
    drv();
    req_valid = 4'h0;
    smp();
    chk("single_exec", {req_ready, 3'b0, rsp_valid}, 0);
    drv();
    smp();
    chk("single_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry}, {1'b1, 2'd1, 4'h8, 1'b0});
    drv();
    smp();
    chk("single_hold", {rsp_valid, rsp_result}, {1'b0, 4'h8});

    // carry from requester 0: F + 1
    drv();
    req_valid = 4'b0001;
    req_op_a  = 16'h000F;
    req_op_b  = 16'h0001;
    smp();
    chk("carry_ready", req_ready, 4'b0001);
    drv();
    req_valid = 4'h0;
    drv();
    smp();
    chk("carry_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry}, {1'b1, 2'd0, 4'h0, 1'b1});

    // round robin after a fresh reset: operands a=i, b=i+1
    drv();
    rst = 1'b1;
    drv();
    rst       = 1'b0;
    req_valid = 4'hF;
    req_op_a  = 16'h3210;
    req_op_b  = 16'h4321;
    g = 0;
    r = 0;
    last = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (rsp_valid) begin
        chk("rr_rsp_id", rsp_id, rr_exp[r]);
        chk("rr_rsp_res", rsp_result, 2 * rr_exp[r] + 1);
        r++;
      end
      if (req_ready != 4'h0) begin
        chk("rr_grant", req_ready, 1 << rr_exp[g]);
        if (g > 0) chk("rr_gap", c - last, 3);
        last = c;
        g++;
      end
      if (g == 5) break;
    end
    chk("rr_done", g, 5);

    // backpressure on the response of requester 0
    drv();
    rsp_ready = 1'b0;
    drv();
    smp();
    chk("bp_rsp", {rsp_valid, rsp_id, rsp_result}, {1'b1, 2'd0, 4'h1});
    for (int c = 0; c < 5; c++) begin
      drv();
      smp();
      chk("bp_hold", {rsp_valid, rsp_id, rsp_result, req_ready}, {1'b1, 2'd0, 4'h1, 4'h0});
    end
    drv();
    rsp_ready = 1'b1;
    smp();
    chk("bp_release", {rsp_valid, req_ready}, {1'b1, 4'h0});
    drv();
    smp();
    chk("bp_next_grant", req_ready, 4'b0010);
    chk("bp_after", {rsp_valid, rsp_result}, {1'b0, 4'h1});

    // reset during EXEC drops the operation
    drv();
    rst       = 1'b1;
    req_valid = 4'h0;
    drv();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("mid_rst_no_rsp", rsp_valid, 0);
      drv();
    end
`ifdef TOXIC_ALU_ARB_PERF_EN
    chk("mid_rst_perf", {perf_grant_cnt, perf_stall_cnt}, 0);
`endif
    req_valid = 4'hF;
    smp();
    chk("mid_rst_req0", req_ready, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
